// File: rtl/maxpool2d_stream_if.sv
// maxpool2d_stream_if
//   Groups the control, input-stream and pooled-output signals of
//   maxpool2d_stream. The slave modport is the pooling block. The master
//   modport is whoever drives start/in_* and consumes the out_* stream.
//   Signals:
//     start, done       pass control (start pulse in, done level out)
//     in_data, in_valid conv output stream (32-bit signed, no ready)
//     out_data/addr/chan, out_valid  pooled, saturated, tagged result
//     err               sticky protocol error
interface maxpool2d_stream_if #(
    parameter int AW = 8
) ();
    logic          start;
    logic          done;
    logic [31:0]   in_data;
    logic          in_valid;
    logic [15:0]   out_data;
    logic [AW-1:0] out_addr;
    logic [3:0]    out_chan;
    logic          out_valid;
    logic          err;

    modport slave (
        input  start, in_data, in_valid,
        output done, out_data, out_addr, out_chan, out_valid, err
    );

    modport master (
        output start, in_data, in_valid,
        input  done, out_data, out_addr, out_chan, out_valid, err
    );
endinterface

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream
//   Streaming 2x2 / stride-2 max-pool stage. Samples arrive filter-major,
//   then row, then column, one per in_valid, with no backpressure. A hold
//   register keeps the even-column sample. A line buffer of WIDTH/2 entries
//   keeps the horizontal maxima of each even row. On every odd-row/odd-column
//   sample the window maximum is saturated to 16 bits and emitted with its
//   pooled address and channel.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-low reset
//     bus  maxpool2d_stream_if.slave (start/done, in_*, out_*, err)
//
//   state  | meaning
//   S_IDLE | waiting for start after reset
//   S_RUN  | accepting samples of a pass
//   S_DONE | pass complete, done held until next start
module maxpool2d_stream #(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int CHANNELS = 16,
    parameter int AW       = 8
) (
    input  logic clk,
    input  logic rst,
    maxpool2d_stream_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int LW = CW - 1;
    localparam int PW = WIDTH / 2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [3:0]        chan_q, chan_d;
    logic signed [31:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic [AW-1:0]     out_addr_q, out_addr_d;
    logic [3:0]        out_chan_q, out_chan_d;

    logic signed [31:0] linebuf_q [PW];
    logic               lb_we;
    logic [LW-1:0]      lb_idx;
    logic signed [31:0] x, h, lb_rd, v;
    logic [15:0]        v_sat;
    logic [AW-1:0]      addr_calc;
    logic               last_col, last_row, last_chan;

    assign x         = $signed(bus.in_data);
    assign lb_idx    = col_q[CW-1:1];
    assign lb_rd     = linebuf_q[lb_idx];
    assign h         = (x > hold_q) ? x : hold_q;
    assign v         = (lb_rd > h) ? lb_rd : h;
    assign addr_calc = AW'(row_q >> 1) * AW'(PW) + AW'(col_q >> 1);
    assign last_col  = (col_q == CW'(WIDTH - 1));
    assign last_row  = (row_q == RW'(HEIGHT - 1));
    assign last_chan = (chan_q == 4'(CHANNELS - 1));

    always_comb begin
        if (v > 32'sd32767)
            v_sat = 16'h7FFF;
        else if (v < -32'sd32768)
            v_sat = 16'h8000;
        else
            v_sat = v[15:0];
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        chan_d      = chan_q;
        hold_d      = hold_q;
        done_d      = done_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_chan_d  = out_chan_q;
        lb_we       = 1'b0;
        err_d       = err_q | (bus.in_valid & (state_q != S_RUN));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    chan_d  = '0;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    if (!col_q[0]) begin
                        hold_d = x;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = v_sat;
                        out_addr_d  = addr_calc;
                        out_chan_d  = chan_q;
                    end
                    col_d = col_q + 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (last_row) begin
                            row_d  = '0;
                            chan_d = chan_q + 1'b1;
                            if (last_chan) begin
                                // Final emit and done rise on the same edge.
                                chan_d  = '0;
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            chan_q      <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            chan_q      <= chan_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_chan_q  <= out_chan_d;
        end
    end

    // Line buffer needs no reset; every entry is written on an even row
    // before it is read on the following odd row.
    always_ff @(posedge clk) begin
        if (rst && lb_we)
            linebuf_q[lb_idx] <= h;
    end

    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb_maxpool2d_stream
//   Three instances: 4x4x1 (a), 4x4x2 (b), 32x32x16 (c). Expected pooled
//   outputs come from a direct 2x2 window maximum over the stimulus image
//   and are queued when the triggering sample is issued. A negedge monitor
//   pops and compares each out_valid.
`timescale 1ns/1ps
module tb_maxpool2d_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxpool2d_stream_if #(.AW(8)) ifa ();
    maxpool2d_stream_if #(.AW(8)) ifb ();
    maxpool2d_stream_if #(.AW(8)) ifc ();

    maxpool2d_stream #(.WIDTH(4), .HEIGHT(4), .CHANNELS(1), .AW(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    maxpool2d_stream #(.WIDTH(4), .HEIGHT(4), .CHANNELS(2), .AW(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    maxpool2d_stream #(.WIDTH(32), .HEIGHT(32), .CHANNELS(16), .AW(8))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct {
        int data;
        int addr;
        int chan;
        int edge_n;
        bit last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   img [16384];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_emit(input string tag, input exp_t e, input int d,
                              input int a, input int c, input int dn);
        chk({tag, "_data"}, d, e.data);
        chk({tag, "_addr"}, a, e.addr);
        chk({tag, "_chan"}, c, e.chan);
        chk({tag, "_latency_edge"}, cyc, e.edge_n);
        chk({tag, "_done_with_emit"}, dn, int'(e.last));
    endtask

    exp_t ea, eb, ec;
    always @(negedge clk) begin
        if (ifa.out_valid) begin
            if (qa.size() == 0) chk("a_spurious_valid", int'(ifa.out_valid), 0);
            else begin
                ea = qa.pop_front();
                check_emit("a", ea, int'($signed(ifa.out_data)), int'(ifa.out_addr),
                           int'(ifa.out_chan), int'(ifa.done));
            end
        end
        if (ifb.out_valid) begin
            if (qb.size() == 0) chk("b_spurious_valid", int'(ifb.out_valid), 0);
            else begin
                eb = qb.pop_front();
                check_emit("b", eb, int'($signed(ifb.out_data)), int'(ifb.out_addr),
                           int'(ifb.out_chan), int'(ifb.done));
            end
        end
        if (ifc.out_valid) begin
            if (qc.size() == 0) chk("c_spurious_valid", int'(ifc.out_valid), 0);
            else begin
                ec = qc.pop_front();
                check_emit("c", ec, int'($signed(ifc.out_data)), int'(ifc.out_addr),
                           int'(ifc.out_chan), int'(ifc.done));
            end
        end
    end

    task automatic set_in(input int w, input logic v, input int d);
        case (w)
            0: begin ifa.in_valid = v; ifa.in_data = d; end
            1: begin ifb.in_valid = v; ifb.in_data = d; end
            default: begin ifc.in_valid = v; ifc.in_data = d; end
        endcase
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0: ifa.start = v;
            1: ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    task automatic push(input int w, input exp_t e);
        case (w)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int w);
        case (w)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic int get_done(input int w);
        case (w)
            0: return int'(ifa.done);
            1: return int'(ifb.done);
            default: return int'(ifc.done);
        endcase
    endfunction

    function automatic int get_err(input int w);
        case (w)
            0: return int'(ifa.err);
            1: return int'(ifb.err);
            default: return int'(ifc.err);
        endcase
    endfunction

    // All outputs packed together; zero only when every output is zero.
    function automatic int outs(input int w);
        case (w)
            0: return int'({1'b0, ifa.done, ifa.out_valid, ifa.err, ifa.out_data, ifa.out_addr, ifa.out_chan});
            1: return int'({1'b0, ifb.done, ifb.out_valid, ifb.err, ifb.out_data, ifb.out_addr, ifb.out_chan});
            default: return int'({1'b0, ifc.done, ifc.out_valid, ifc.err, ifc.out_data, ifc.out_addr, ifc.out_chan});
        endcase
    endfunction

    function automatic int gold(input int W, input int H, input int c, input int pr, input int pc);
        int b;
        int m;
        b = c * W * H + (2 * pr) * W + 2 * pc;
        m = img[b];
        if (img[b + 1] > m) m = img[b + 1];
        if (img[b + W] > m) m = img[b + W];
        if (img[b + W + 1] > m) m = img[b + W + 1];
        if (m > 32767) return 32767;
        if (m < -32768) return -32768;
        return m;
    endfunction

    task automatic run_pass(input int w, input int W, input int H, input int C,
                            input int maxgap, input int limit);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        chk("done_cleared_by_start", get_done(w), 0);
        for (int c = 0; c < C; c++)
            for (int r = 0; r < H; r++)
                for (int col = 0; col < W; col++)
                    if (n < limit) begin
                        set_in(w, 1'b1, img[c * W * H + r * W + col]);
                        if ((r % 2 == 1) && (col % 2 == 1)) begin
                            e.data   = gold(W, H, c, r / 2, col / 2);
                            e.addr   = (r / 2) * (W / 2) + col / 2;
                            e.chan   = c;
                            e.edge_n = cyc + 1;
                            e.last   = (c == C - 1) && (r == H - 1) && (col == W - 1);
                            push(w, e);
                        end
                        @(negedge clk);
                        set_in(w, 1'b0, 0);
                        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
                        n++;
                    end
        repeat (4) @(negedge clk);
        chk("emits_outstanding", qsize(w), 0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) img[i] = i;
    endtask

    initial begin
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            set_in(w, 1'b0, 0);
            set_start(w, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) chk("reset_outputs_zero", outs(w), 0);
        rst = 1'b1;

        // Ramp 0..15: expects 5, 7, 13, 15 at addr 0..3.
        load_ramp();
        run_pass(0, 4, 4, 1, 0, 16);
        chk("a_done_after_ramp", get_done(0), 1);
        chk("a_last_value_15", int'($signed(ifa.out_data)), 15);

        // Saturation: 40000 in window 0, -70000 in window 3, rest -70001.
        for (int i = 0; i < 16; i++) img[i] = -70001;
        img[0]  = 40000;
        img[10] = -70000;
        run_pass(0, 4, 4, 1, 0, 16);
        chk("a_done_after_sat", get_done(0), 1);
        chk("a_last_value_neg_sat", int'($signed(ifa.out_data)), -32768);

        // Two channels with random gaps.
        for (int i = 0; i < 32; i++) img[i] = int'($urandom_range(0, 255));
        run_pass(1, 4, 4, 2, 7, 32);
        chk("b_done_after_gaps", get_done(1), 1);

        // Partial pass of 20 samples, then a one-cycle reset.
        for (int i = 0; i < 32; i++) img[i] = int'($urandom_range(1, 1000));
        run_pass(1, 4, 4, 2, 0, 20);
        chk("b_not_done_partial", get_done(1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("b_outputs_after_reset", outs(1), 0);
        chk("a_outputs_after_reset", outs(0), 0);
        repeat (10) @(negedge clk);
        chk("b_quiet_after_reset", outs(1), 0);
        load_ramp();
        for (int i = 16; i < 32; i++) img[i] = 31 - i;
        run_pass(1, 4, 4, 2, 0, 32);
        chk("b_done_after_rerun", get_done(1), 1);

        // Full default geometry, back-to-back, signed data crossing both rails.
        for (int i = 0; i < 16384; i++) img[i] = int'($urandom_range(0, 140000)) - 70000;
        run_pass(2, 32, 32, 16, 0, 16384);
        chk("c_done_after_full", get_done(2), 1);

        // Stray in_valid in idle, then a normal pass, then in_valid after done.
        chk("a_err_clear_initially", get_err(0), 0);
        set_in(0, 1'b1, 99);
        @(negedge clk);
        set_in(0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("a_err_set_in_idle", get_err(0), 1);
        load_ramp();
        run_pass(0, 4, 4, 1, 0, 16);
        chk("a_done_after_err_idle", get_done(0), 1);
        chk("a_err_sticky", get_err(0), 1);
        set_in(0, 1'b1, 1234);
        @(negedge clk);
        set_in(0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("a_err_after_done", get_err(0), 1);
        chk("a_done_held", get_done(0), 1);
        run_pass(0, 4, 4, 1, 0, 16);
        chk("a_done_final", get_done(0), 1);
        chk("a_err_still_sticky", get_err(0), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
